// File: rtl/onset_enumerator.sv
`default_nettype none
// ============================================================================
// Module      : onset_enumerator
// Description : Sweeps every input vector of a combinational single-output
//               function and streams each on-set minterm over valid/ready,
//               counting the on-set size.
// Revision    : 1.0 - initial release
// ============================================================================
module onset_enumerator #(
    parameter int unsigned N_IN = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] dut_x,
    input  logic            dut_y,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [N_IN-1:0] m_data,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   onset_count
);

    localparam logic [1:0] c_s_idle = 2'd0;
    localparam logic [1:0] c_s_scan = 2'd1;
    localparam logic [1:0] c_s_emit = 2'd2;
    localparam logic [1:0] c_s_done = 2'd3;

    logic [1:0]      r_state;
    logic [N_IN-1:0] r_cnt;
    logic [N_IN-1:0] r_m_data;
    logic [N_IN:0]   r_onset_count;

    logic [1:0]      w_state_nxt;
    logic [N_IN-1:0] w_cnt_nxt;
    logic [N_IN-1:0] w_m_data_nxt;
    logic [N_IN:0]   w_onset_count_nxt;
    logic            w_last;

    // The all-ones vector is the final one; the counter never wraps.
    assign w_last = &r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_s_idle;
            r_cnt         <= '0;
            r_m_data      <= '0;
            r_onset_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_m_data      <= w_m_data_nxt;
            r_onset_count <= w_onset_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_m_data_nxt      = r_m_data;
        w_onset_count_nxt = r_onset_count;
        case (r_state)
            c_s_idle, c_s_done: begin
                if (start) begin
                    w_cnt_nxt         = '0;
                    w_onset_count_nxt = '0;
                    w_state_nxt       = c_s_scan;
                end
            end
            c_s_scan: begin
                if (dut_y) begin
                    w_m_data_nxt = r_cnt;
                    w_state_nxt  = c_s_emit;
                end else if (w_last) begin
                    w_state_nxt = c_s_done;
                end else begin
                    w_cnt_nxt = r_cnt + N_IN'(1);
                end
            end
            c_s_emit: begin
                if (m_ready) begin
                    w_onset_count_nxt = r_onset_count + (N_IN+1)'(1);
                    if (w_last) begin
                        w_state_nxt = c_s_done;
                    end else begin
                        w_cnt_nxt   = r_cnt + N_IN'(1);
                        w_state_nxt = c_s_scan;
                    end
                end
            end
            default: w_state_nxt = c_s_idle;
        endcase
    end

    // Status and stream-valid are decoded directly from the state register.
    assign dut_x       = r_cnt;
    assign m_data      = r_m_data;
    assign m_valid     = (r_state == c_s_emit);
    assign busy        = (r_state == c_s_scan) || (r_state == c_s_emit);
    assign done        = (r_state == c_s_done);
    assign onset_count = r_onset_count;

endmodule
`default_nettype wire

// File: tb/tb_onset_enumerator.sv
`default_nettype none
// ============================================================================
// Module      : tb_onset_enumerator
// Description : Scoreboard bench for onset_enumerator (N_IN=15 and N_IN=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_onset_enumerator;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // 15-input instance: function is constant 0 (mode 0) or AND of all inputs (mode 1)
    logic        start15, ready15, y15, valid15, busy15, done15;
    logic [14:0] x15, data15;
    logic [15:0] cnt15;
    int          mode15 = 0;
    assign y15 = (mode15 == 1) ? (&x15) : 1'b0;

    // 4-input instance: function is an arbitrary truth table
    logic        start4, ready4, y4, valid4, busy4, done4;
    logic [3:0]  x4, data4;
    logic [4:0]  cnt4;
    logic [15:0] tt4 = '0;
    assign y4 = tt4[x4];

    onset_enumerator #(.N_IN(15)) u_dut15 (
        .clk(clk), .rst(rst), .start(start15), .dut_x(x15), .dut_y(y15),
        .m_valid(valid15), .m_ready(ready15), .m_data(data15),
        .busy(busy15), .done(done15), .onset_count(cnt15)
    );

    onset_enumerator #(.N_IN(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .dut_x(x4), .dut_y(y4),
        .m_valid(valid4), .m_ready(ready4), .m_data(data4),
        .busy(busy4), .done(done4), .onset_count(cnt4)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard queues filled by the reference model at sweep start
    logic [14:0] q15[$];
    logic [3:0]  q4[$];
    logic [3:0]  hold4;
    bit          holding4 = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (valid15 && ready15) begin
                if (q15.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL m15_extra: actual 0x%0h required none", data15);
                end else begin
                    check("m15_data", data15, q15.pop_front());
                end
            end
            if (valid4) begin
                if (holding4) check("m4_stall_stable", data4, hold4);
                if (ready4) begin
                    if (q4.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL m4_extra: actual 0x%0h required none", data4);
                    end else begin
                        check("m4_data", data4, q4.pop_front());
                    end
                end
                holding4 = !ready4;
                hold4    = data4;
            end else begin
                holding4 = 1'b0;
            end
        end
    end

    // mode15: function select; pulse_at: vector at which a stray start is pulsed (-1 none)
    task automatic run15(input int mode, input int pulse_at, input int exp_cycles, input int exp_count);
        int  c;
        bit  pending;
        bit  pulsed;
        mode15  = mode;
        pending = 1'b0;
        pulsed  = 1'b0;
        if (mode == 1) q15.push_back(15'h7FFF);
        @(posedge clk); #1 start15 = 1'b1;
        @(posedge clk); #1 start15 = 1'b0;
        check("s15_start_x", x15, 0);
        check("s15_start_done", done15, 0);
        check("s15_start_count", cnt15, 0);
        check("s15_start_busy", busy15, 1);
        c = 0;
        while (c < exp_cycles + 64) begin
            @(posedge clk); #1;
            c++;
            if (pending) begin
                start15 = 1'b0;
                pending = 1'b0;
                check("s15_no_restart", x15, pulse_at + 1);
            end
            if (done15) break;
            if (!pulsed && pulse_at >= 0 && int'(x15) == pulse_at) begin
                start15 = 1'b1;
                pending = 1'b1;
                pulsed  = 1'b1;
            end
        end
        check("s15_cycles", c, exp_cycles);
        check("s15_done", done15, 1);
        check("s15_busy", busy15, 0);
        check("s15_count", cnt15, exp_count);
        check("s15_x_end", x15, 15'h7FFF);
        check("s15_queue_left", q15.size(), 0);
    endtask

    // rmode: 0 ready tied high, 1 pattern 1,0,0,1, 2 random
    task automatic run4(input logic [15:0] tt, input int rmode);
        int c;
        int phase;
        int ones;
        tt4  = tt;
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            if (tt[i]) begin
                q4.push_back(4'(i));
                ones++;
            end
        end
        phase  = 0;
        ready4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        check("s4_start_x", x4, 0);
        check("s4_start_count", cnt4, 0);
        check("s4_start_done", done4, 0);
        c = 0;
        while (c < 400) begin
            @(posedge clk); #1;
            c++;
            phase = (phase + 1) % 4;
            case (rmode)
                1:       ready4 = (phase == 0) || (phase == 3);
                2:       ready4 = 1'($urandom_range(0, 1));
                default: ready4 = 1'b1;
            endcase
            if (done4) break;
        end
        if (rmode == 0) check("s4_cycles", c, 16 + ones);
        check("s4_done", done4, 1);
        check("s4_count", cnt4, ones);
        check("s4_x_end", x4, 4'hF);
        check("s4_queue_left", q4.size(), 0);
        ready4 = 1'b1;
    endtask

    initial begin
        int c;
        rst = 1'b1; start15 = 1'b0; start4 = 1'b0; ready15 = 1'b1; ready4 = 1'b1;
        #12;
        check("rst_x15", x15, 0);
        check("rst_valid15", valid15, 0);
        check("rst_busy15", busy15, 0);
        check("rst_done15", done15, 0);
        check("rst_count15", cnt15, 0);
        check("rst_data4", data4, 0);
        @(negedge clk); rst = 1'b0;

        run4(16'hAAAA, 1);
        run4(16'hFFFF, 0);
        check("s4_count_msb", cnt4[4], 1);
        for (int k = 0; k < 4; k++) run4(16'($urandom), 2);
        run4(16'h0000, 0);

        // Reset while a minterm is stalled in the output stage
        ready4 = 1'b0;
        tt4    = 16'h8420;
        @(posedge clk); #1 start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        c = 0;
        while (!valid4 && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        check("emit_seen", valid4, 1);
        check("emit_data", data4, 4'h5);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("arst_valid4", valid4, 0);
        check("arst_data4", data4, 0);
        check("arst_x4", x4, 0);
        check("arst_busy4", busy4, 0);
        check("arst_done4", done4, 0);
        check("arst_count4", cnt4, 0);
        q4.delete();
        holding4 = 1'b0;
        @(negedge clk); rst = 1'b0;
        run4(16'h8420, 0);

        run15(1, -1, 32769, 1);
        run15(0, 16'h10, 32768, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
